// File: rtl/debounce_sync2.sv
// Two-channel input conditioner: two-flop synchroniser, per-channel STABLE/CHECK
// debounce FSM with stability counter, registered level plus one-cycle edge strobes.
module debounce_sync2 #(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_BITS        = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] clean_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             change
);

    typedef enum logic {
        STABLE = 1'b0,
        CHECK  = 1'b1
    } state_t;

    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);

    logic [WIDTH-1:0]    s1;
    logic [WIDTH-1:0]    s2;
    state_t              state_q [WIDTH];
    state_t              state_d [WIDTH];
    logic [CNT_BITS-1:0] cnt_q   [WIDTH];
    logic [CNT_BITS-1:0] cnt_d   [WIDTH];
    logic [WIDTH-1:0]    clean_d;
    logic [WIDTH-1:0]    rise_d;
    logic [WIDTH-1:0]    fall_d;
    logic                change_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1        <= '0;
            s2        <= '0;
            clean_out <= '0;
            rise      <= '0;
            fall      <= '0;
            change    <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= STABLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            s1        <= raw_in;
            s2        <= s1;
            clean_out <= clean_d;
            rise      <= rise_d;
            fall      <= fall_d;
            change    <= change_d;
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Strobes are computed alongside the level so they appear with the new clean_out.
    always_comb begin
        clean_d = clean_out;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                STABLE: begin
                    if (s2[i] != clean_out[i]) begin
                        state_d[i] = CHECK;
                        cnt_d[i]   = CNT_ONE;
                    end else begin
                        cnt_d[i] = '0;
                    end
                end
                CHECK: begin
                    if (s2[i] == clean_out[i]) begin
                        state_d[i] = STABLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        clean_d[i] = s2[i];
                        rise_d[i]  = s2[i];
                        fall_d[i]  = ~s2[i];
                        state_d[i] = STABLE;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
            endcase
        end
        change_d = |{rise_d, fall_d};
    end

endmodule

// File: doc/debounce_sync2.md
Name: debounce_sync2

Overview:
- Two-channel input conditioner that sits directly upstream of the lab Mealy state machine and drives its 2-bit data input.
- Synchronises two raw asynchronous inputs (push-buttons or switches) to clock and rejects contact bounce.
- Presents a stable 2-bit word plus per-channel one-cycle edge strobes.
- Each channel is an independent sync chain, 2-state FSM and stability counter.

Parameters:
- WIDTH, 2: number of channels. The consumer takes exactly 2.
- DEBOUNCE_CYCLES, 4: consecutive differing cycles required before clean_out updates. Must be >= 2; below 2 is illegal and is not checked in RTL.
- CNT_BITS, 3: counter width. Must satisfy 2^CNT_BITS > DEBOUNCE_CYCLES-1.

Ports:
- clock, input, 1: system clock, rising-edge active.
- reset, input, 1: asynchronous, active-low reset.
- raw_in, input, WIDTH: unsynchronised raw channel inputs.
- clean_out, output, WIDTH: debounced level per channel; feeds the FSM data input.
- rise, output, WIDTH: one-cycle pulse when clean_out[i] goes 0->1.
- fall, output, WIDTH: one-cycle pulse when clean_out[i] goes 1->0.
- change, output, 1: OR of all rise and fall bits.

Behaviour:

Reset (reset=0, asynchronous, applied immediately without waiting for a clock edge):
- s1, s2, clean_out, rise, fall, change all = 0.
- Counters = 0; every channel FSM = STABLE.
- Reset mid-count discards the partial count with no pulse.
- After release, a channel held at 1 debounces normally and produces one rise pulse.

Synchroniser, per channel i:
- s1[i] <= raw_in[i]; s2[i] <= s1[i].
- Only s2 is used by the FSM. raw_in is never used combinationally.

FSM, per channel, evaluated at each rising edge:
- STABLE, s2 == clean: stay in STABLE, cnt <= 0.
- STABLE, s2 != clean: go to CHECK, cnt <= 1.
- CHECK, s2 == clean: bounce rejected. Go to STABLE, cnt <= 0, no output change.
- CHECK, s2 != clean, cnt < DEBOUNCE_CYCLES-1: stay in CHECK, cnt <= cnt+1.
- CHECK, s2 != clean, cnt == DEBOUNCE_CYCLES-1: clean <= s2, go to STABLE, cnt <= 0, and in the same edge:
  - rise[i] <= s2 if clean was 0;
  - fall[i] <= 1 if clean was 1.
- The counter never exceeds DEBOUNCE_CYCLES-1 and never wraps.

Pulses:
- rise, fall and change are registered and are high for exactly one cycle, the cycle in which the new clean_out is first visible.
- They are cleared on the next edge unless a new update occurs.

Latency:
- raw_in settles before edge E0 and stays stable. clean_out changes at edge E0+DEBOUNCE_CYCLES+1.
- With the default of 4, the update lands on the 6th edge counting E0.

Glitch rejection:
- Any raw pulse whose synchronised image lasts <= DEBOUNCE_CYCLES-1 cycles never reaches clean_out.

Independence and simultaneous events:
- Channels are fully independent.
- Simultaneous updates on both channels assert both strobe bits in the same cycle; change is high once.

Steady state and constraints:
- With raw_in constant, outputs stay constant indefinitely and no strobes occur.
- Metastability on s1 is tolerated. s2 is treated as clean.

Test Plan (DEBOUNCE_CYCLES=4):
1. Reset:
   - Stimulus: hold reset=0 with raw_in=2'b11, then release.
   - Required: all outputs 0 during reset. clean_out=2'b11 at the 6th edge after release, with rise=2'b11 and change=1 for exactly one cycle.
2. Clean press on channel 0:
   - Stimulus: raw_in 00->01 before edge E0.
   - Required: clean_out=01 at E0+5, rise=01 for one cycle, fall=00.
   - Stimulus: later raw_in 01->00.
   - Required: fall=01 five edges after the change settles.
3. Bounce:
   - Stimulus: raw_in[1] toggles 0,1,0,1,0 each clock, then settles at 1.
   - Required: no strobe during the toggling. clean_out[1]=1 exactly 5 edges after the last settle, with a single rise pulse.
4. Short glitch:
   - Stimulus: raw_in[0] high for 3 cycles, then low.
   - Required: clean_out stays 00, and rise, fall and change stay 0 throughout.
5. Simultaneous:
   - Stimulus: raw_in 01->10 at the same edge.
   - Required: clean_out=10 after 5 edges, rise=10 and fall=01 in the same cycle, change=1 for one cycle.
6. Reset mid-count:
   - Stimulus: raw_in 00->11, then assert reset 3 cycles later, release, and keep raw_in=11.
   - Required: no pulse before reset. A full 5-edge count restarts after release, ending in a single rise=11 pulse.
